framebuffer_writer: RTL and testbench
=====================================

Name: framebuffer_writer

Overview:
- Write side of the double-buffered 64x64 LED matrix framebuffer.
- Accepts pixel-write, clear and swap commands from the CPU/bus through a valid/ready handshake.
- Writes into the back buffer of two pixel RAMs: RAM0 holds rows 0-31, RAM1 holds rows 32-63.
- Flips the front/back buffer only on the display scanner's end-of-frame `done` pulse, so the panel never shows a half-drawn frame.

Parameters:
- COLUMN_BITS, 6, log2 of columns per row (64).
- HALF_ROW_BITS, 5, log2 of rows per RAM half (32).
- DATA_BITS, 8, pixel word width {2'b00, R[1:0], G[1:0], B[1:0]}.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  asynchronous, active-high reset.
- cmdValid  input  1  command present.
- cmdReady  output  1  block can accept a command this cycle.
- cmdOp  input  2  00 = write pixel, 01 = clear back buffer, 10 = swap, 11 = reserved (no-op).
- cmdX  input  6  column 0-63.
- cmdY  input  6  row 0-63; bit 5 selects the RAM.
- cmdColor  input  6  {R,G,B}, two bits each.
- displayDone  input  1  one-cycle end-of-frame pulse from the display scanner.
- frontBuffer  output  1  buffer currently shown; the display uses it as its address MSB.
- swapPending  output  1  swap accepted, waiting for displayDone.
- ramAddr0  output  12  {backBuffer, row[4:0], col[5:0]}, RAM0 write address.
- ramData0  output  8  RAM0 write data.
- ramWe0  output  1  RAM0 write enable.
- ramAddr1  output  12  RAM1 write address, same format as ramAddr0.
- ramData1  output  8  RAM1 write data.
- ramWe1  output  1  RAM1 write enable.

Behaviour:
- backBuffer = ~frontBuffer at all times.
- Reset values: state IDLE, frontBuffer=0, swapPending=0, ramWe0/1=0, ramAddr0/1=0, ramData0/1=0, clear counter=0.
- cmdReady=1 only in IDLE while rst=0. A command is accepted when cmdValid && cmdReady are high on a posedge.
- States: IDLE, WRITE, CLEAR, WAIT_SWAP.
- IDLE, on accept:
  - op 00 -> WRITE.
  - op 01 -> CLEAR.
  - op 10 -> WAIT_SWAP.
  - op 11 -> stays in IDLE, no side effect.
  - Command fields are registered at accept.
- WRITE (exactly 1 cycle):
  - If Y[5]=0: ramWe0=1, ramAddr0={backBuffer, Y[4:0], X}, ramData0={2'b00, color}.
  - If Y[5]=1: the same on the RAM1 ports.
  - The other RAM's we stays 0. Returns to IDLE.
  - Latency: accept edge -> we high in the following cycle -> cmdReady high again the cycle after.
  - Back-to-back writes sustain one per 2 cycles.
- CLEAR (2048 cycles):
  - Both ramWe0 and ramWe1 = 1.
  - Address {backBuffer, count[10:0]}, count 0..2047; data {2'b00, color}.
  - Counter is 11 bits and wraps to 0 after 2047. On that wrap the state returns to IDLE and the counter is left at 0.
  - cmdReady=0 throughout.
- WAIT_SWAP:
  - swapPending=1, cmdReady=0, no RAM writes.
  - A displayDone in the accept cycle is ignored. Only a displayDone seen while in WAIT_SWAP counts, which guarantees one full frame of the previous front buffer.
  - On a counted displayDone: frontBuffer toggles on that edge, swapPending=0 the next cycle, state returns to IDLE.
- displayDone in IDLE, WRITE or CLEAR: ignored.
- Writes never target the front buffer. The address MSB always equals backBuffer sampled in the write cycle.
- Outputs are registered; ramWe is never high for more than one RAM word per cycle per port.
- Reset asserted mid-CLEAR or mid-WAIT_SWAP:
  - Immediate abort, outputs go to reset values asynchronously.
  - Pending swap is discarded; frontBuffer=0.
- Unreachable state encoding -> IDLE with outputs deasserted.

Test Plan:
- Reset, then write X=5, Y=3, color=6'b110001 -> next cycle ramWe0=1, ramAddr0=12'h8C5 ({1, 5'd3, 6'd5}), ramData0=8'h31; ramWe1=0; cmdReady low for 1 cycle.
- Write X=63, Y=40 -> ramWe1=1, ramAddr1={1, 5'd8, 6'd63}=12'hA3F; ramWe0 stays 0.
- Clear with color 0 -> exactly 2048 cycles with ramWe0 and ramWe1 both high, addresses 12'h800..12'hFFF, then IDLE with cmdReady=1.
- Swap with displayDone pulsed in the accept cycle and again 100 cycles later -> frontBuffer stays 0 through the first pulse, becomes 1 at the second; the next pixel write uses address MSB 0.
- displayDone pulses in IDLE and during CLEAR -> frontBuffer unchanged.
- Assert rst 500 cycles into a CLEAR -> ramWe0/1 drop immediately, frontBuffer=0, IDLE and cmdReady=1 after release; reserved op 11 -> no writes, cmdReady stays 1.

Source files
------------

// File: rtl/framebuffer_writer.sv
// Write side of the double-buffered 64x64 LED framebuffer: pixel writes, back-buffer
// clears and frame-synchronous buffer swaps into two half-panel pixel RAMs.
module framebuffer_writer #(
  parameter int COLUMN_BITS   = 6,
  parameter int HALF_ROW_BITS = 5,
  parameter int DATA_BITS     = 8
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   cmdValid,
  output logic                                   cmdReady,
  input  logic [1:0]                             cmdOp,
  input  logic [COLUMN_BITS-1:0]                 cmdX,
  input  logic [HALF_ROW_BITS:0]                 cmdY,
  input  logic [DATA_BITS-3:0]                   cmdColor,
  input  logic                                   displayDone,
  output logic                                   frontBuffer,
  output logic                                   swapPending,
  output logic [HALF_ROW_BITS+COLUMN_BITS:0]     ramAddr0,
  output logic [DATA_BITS-1:0]                   ramData0,
  output logic                                   ramWe0,
  output logic [HALF_ROW_BITS+COLUMN_BITS:0]     ramAddr1,
  output logic [DATA_BITS-1:0]                   ramData1,
  output logic                                   ramWe1
);

  localparam int CNT_BITS  = HALF_ROW_BITS + COLUMN_BITS;
  localparam int ADDR_BITS = CNT_BITS + 1;
  localparam logic [CNT_BITS-1:0] CNT_LAST = '1;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITE     = 2'd1,
    ST_CLEAR     = 2'd2,
    ST_WAIT_SWAP = 2'd3
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic                   r_front, w_front_nxt;
  logic                   r_swap, w_swap_nxt;
  logic [CNT_BITS-1:0]    r_count, w_count_nxt;
  logic                   r_we0, w_we0_nxt, r_we1, w_we1_nxt;
  logic [ADDR_BITS-1:0]   r_addr0, w_addr0_nxt, r_addr1, w_addr1_nxt;
  logic [DATA_BITS-1:0]   r_data0, w_data0_nxt, r_data1, w_data1_nxt;
  logic                   w_back;
  logic [DATA_BITS-1:0]   w_pixel;
  logic [CNT_BITS-1:0]    w_count_inc;

  assign w_back      = ~r_front;
  assign w_pixel     = {2'b00, cmdColor};
  assign w_count_inc = r_count + {{(CNT_BITS-1){1'b0}}, 1'b1};

  // Next-state and next-output decode; RAM strobes are single-cycle unless refreshed.
  always_comb begin
    w_state_nxt = r_state;
    w_front_nxt = r_front;
    w_swap_nxt  = r_swap;
    w_count_nxt = r_count;
    w_we0_nxt   = 1'b0;
    w_we1_nxt   = 1'b0;
    w_addr0_nxt = r_addr0;
    w_addr1_nxt = r_addr1;
    w_data0_nxt = r_data0;
    w_data1_nxt = r_data1;
    case (r_state)
      ST_IDLE: begin
        if (cmdValid) begin
          case (cmdOp)
            2'b00: begin
              w_state_nxt = ST_WRITE;
              if (cmdY[HALF_ROW_BITS]) begin
                w_we1_nxt   = 1'b1;
                w_addr1_nxt = {w_back, cmdY[HALF_ROW_BITS-1:0], cmdX};
                w_data1_nxt = w_pixel;
              end else begin
                w_we0_nxt   = 1'b1;
                w_addr0_nxt = {w_back, cmdY[HALF_ROW_BITS-1:0], cmdX};
                w_data0_nxt = w_pixel;
              end
            end
            2'b01: begin
              w_state_nxt = ST_CLEAR;
              w_count_nxt = '0;
              w_we0_nxt   = 1'b1;
              w_we1_nxt   = 1'b1;
              w_addr0_nxt = {w_back, {CNT_BITS{1'b0}}};
              w_addr1_nxt = {w_back, {CNT_BITS{1'b0}}};
              w_data0_nxt = w_pixel;
              w_data1_nxt = w_pixel;
            end
            2'b10: begin
              w_state_nxt = ST_WAIT_SWAP;
              w_swap_nxt  = 1'b1;
            end
            default: w_state_nxt = ST_IDLE;
          endcase
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WRITE: w_state_nxt = ST_IDLE;
      ST_CLEAR: begin
        // r_count is the word currently on the bus; the last one ends the sweep.
        if (r_count == CNT_LAST) begin
          w_state_nxt = ST_IDLE;
          w_count_nxt = '0;
        end else begin
          w_count_nxt = w_count_inc;
          w_we0_nxt   = 1'b1;
          w_we1_nxt   = 1'b1;
          w_addr0_nxt = {w_back, w_count_inc};
          w_addr1_nxt = {w_back, w_count_inc};
        end
      end
      ST_WAIT_SWAP: begin
        if (displayDone) begin
          w_front_nxt = ~r_front;
          w_swap_nxt  = 1'b0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_WAIT_SWAP;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_swap_nxt  = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Registered outputs, buffer select and clear counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_front <= 1'b0;
      r_swap  <= 1'b0;
      r_count <= '0;
      r_we0   <= 1'b0;
      r_we1   <= 1'b0;
      r_addr0 <= '0;
      r_addr1 <= '0;
      r_data0 <= '0;
      r_data1 <= '0;
    end else begin
      r_front <= w_front_nxt;
      r_swap  <= w_swap_nxt;
      r_count <= w_count_nxt;
      r_we0   <= w_we0_nxt;
      r_we1   <= w_we1_nxt;
      r_addr0 <= w_addr0_nxt;
      r_addr1 <= w_addr1_nxt;
      r_data0 <= w_data0_nxt;
      r_data1 <= w_data1_nxt;
    end
  end

  assign cmdReady    = (r_state == ST_IDLE) && !rst;
  assign frontBuffer = r_front;
  assign swapPending = r_swap;
  assign ramWe0      = r_we0;
  assign ramWe1      = r_we1;
  assign ramAddr0    = r_addr0;
  assign ramAddr1    = r_addr1;
  assign ramData0    = r_data0;
  assign ramData1    = r_data1;

endmodule

// File: tb/tb_framebuffer_writer.sv
// Bench for framebuffer_writer: table-driven pixel writes plus clear, swap and reset
// sequences, with every RAM write checked against a queue of expected writes.
module tb_framebuffer_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmdValid = 1'b0;
  logic        cmdReady;
  logic [1:0]  cmdOp = 2'b00;
  logic [5:0]  cmdX = 6'd0;
  logic [5:0]  cmdY = 6'd0;
  logic [5:0]  cmdColor = 6'd0;
  logic        displayDone = 1'b0;
  logic        frontBuffer, swapPending;
  logic [11:0] ramAddr0, ramAddr1;
  logic [7:0]  ramData0, ramData1;
  logic        ramWe0, ramWe1;

  framebuffer_writer dut (
    .clk(clk), .rst(rst), .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdOp(cmdOp),
    .cmdX(cmdX), .cmdY(cmdY), .cmdColor(cmdColor), .displayDone(displayDone),
    .frontBuffer(frontBuffer), .swapPending(swapPending),
    .ramAddr0(ramAddr0), .ramData0(ramData0), .ramWe0(ramWe0),
    .ramAddr1(ramAddr1), .ramData1(ramData1), .ramWe1(ramWe1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we0;
    logic        we1;
    logic [11:0] addr0;
    logic [11:0] addr1;
    logic [7:0]  data0;
    logic [7:0]  data1;
  } sb_t;

  typedef struct {
    logic [5:0]  x;
    logic [5:0]  y;
    logic [5:0]  color;
    logic        ram1;
    logic [11:0] addr;
    logic [7:0]  data;
  } vec_t;

  sb_t  sb_q[$];
  vec_t vecs[7];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard: every RAM strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (!rst && (ramWe0 || ramWe1)) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_write: got we0=%0b we1=%0b a0=%0h a1=%0h expected none",
                 ramWe0, ramWe1, ramAddr0, ramAddr1);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        chk("we0", ramWe0, e.we0);
        chk("we1", ramWe1, e.we1);
        if (e.we0) begin
          chk("addr0", ramAddr0, e.addr0);
          chk("data0", ramData0, e.data0);
        end
        if (e.we1) begin
          chk("addr1", ramAddr1, e.addr1);
          chk("data1", ramData1, e.data1);
        end
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [5:0] x, input logic [5:0] y,
                      input logic [5:0] color);
    int w;
    w = 0;
    @(negedge clk);
    while (!cmdReady && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!cmdReady) chk("ready_timeout", 32'd0, 32'd1);
    cmdValid = 1'b1;
    cmdOp    = op;
    cmdX     = x;
    cmdY     = y;
    cmdColor = color;
    @(posedge clk);
    #1 cmdValid = 1'b0;
  endtask

  task automatic push_write(input logic ram1, input logic [11:0] addr, input logic [7:0] data);
    sb_t e;
    e.we0 = !ram1;
    e.we1 = ram1;
    e.addr0 = addr;
    e.addr1 = addr;
    e.data0 = data;
    e.data1 = data;
    sb_q.push_back(e);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    vecs[0] = '{6'd5,  6'd3,  6'b110001, 1'b0, 12'h8C5, 8'h31};
    vecs[1] = '{6'd63, 6'd40, 6'b001110, 1'b1, 12'hA3F, 8'h0E};
    vecs[2] = '{6'd0,  6'd0,  6'b000000, 1'b0, 12'h800, 8'h00};
    vecs[3] = '{6'd63, 6'd31, 6'b111111, 1'b0, 12'hFFF, 8'h3F};
    vecs[4] = '{6'd0,  6'd32, 6'b101010, 1'b1, 12'h800, 8'h2A};
    vecs[5] = '{6'd63, 6'd63, 6'b010101, 1'b1, 12'hFFF, 8'h15};
    vecs[6] = '{6'd33, 6'd17, 6'b000011, 1'b0, 12'hC61, 8'h03};

    // Reset values
    repeat (3) @(negedge clk);
    chk("ready_in_reset", cmdReady, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", cmdReady, 1'b1);
    chk("rst_front", frontBuffer, 1'b0);
    chk("rst_swap", swapPending, 1'b0);
    chk("rst_we", {ramWe0, ramWe1}, 2'b00);
    chk("rst_addr", {ramAddr0, ramAddr1}, 24'h0);
    chk("rst_data", {ramData0, ramData1}, 16'h0);

    // Pixel writes from the table, with handshake latency
    for (int i = 0; i < 7; i++) begin
      push_write(vecs[i].ram1, vecs[i].addr, vecs[i].data);
      send(2'b00, vecs[i].x, vecs[i].y, vecs[i].color);
      @(negedge clk);
      chk("wr_ready_low", cmdReady, 1'b0);
      @(negedge clk);
      chk("wr_ready_back", cmdReady, 1'b1);
    end
    chk("wr_drained", sb_q.size(), 0);

    // displayDone while idle is ignored
    @(negedge clk);
    displayDone = 1'b1;
    @(negedge clk);
    displayDone = 1'b0;
    chk("idle_done_front", frontBuffer, 1'b0);

    // Full clear with a displayDone pulse inside it
    for (int i = 0; i < 2048; i++) begin
      sb_t e;
      e.we0 = 1'b1;
      e.we1 = 1'b1;
      e.addr0 = 12'(12'h800 + i);
      e.addr1 = 12'(12'h800 + i);
      e.data0 = 8'h00;
      e.data1 = 8'h00;
      sb_q.push_back(e);
    end
    send(2'b01, 6'd0, 6'd0, 6'd0);
    k = 0;
    @(negedge clk);
    while (!cmdReady && k < 3000) begin
      displayDone = (k == 100);
      @(negedge clk);
      k++;
    end
    displayDone = 1'b0;
    chk("clear_cycles", k, 2048);
    chk("clear_drained", sb_q.size(), 0);
    chk("clear_done_front", frontBuffer, 1'b0);

    // Swap: displayDone in the accept cycle ignored, the later one counts
    @(negedge clk);
    cmdValid = 1'b1;
    cmdOp = 2'b10;
    displayDone = 1'b1;
    @(posedge clk);
    #1;
    cmdValid = 1'b0;
    displayDone = 1'b0;
    @(negedge clk);
    chk("swap_pending", swapPending, 1'b1);
    chk("swap_front_hold", frontBuffer, 1'b0);
    chk("swap_ready_low", cmdReady, 1'b0);
    repeat (99) @(negedge clk);
    chk("swap_front_wait", frontBuffer, 1'b0);
    displayDone = 1'b1;
    @(posedge clk);
    #1 displayDone = 1'b0;
    chk("swap_front_flip", frontBuffer, 1'b1);
    chk("swap_pending_clr", swapPending, 1'b0);
    chk("swap_ready_back", cmdReady, 1'b1);
    push_write(1'b0, 12'h0C5, 8'h31);
    send(2'b00, 6'd5, 6'd3, 6'b110001);
    repeat (2) @(negedge clk);
    chk("post_swap_drained", sb_q.size(), 0);

    // Reset 500 cycles into a clear of buffer 0
    for (int i = 0; i < 500; i++) begin
      sb_t e;
      e.we0 = 1'b1;
      e.we1 = 1'b1;
      e.addr0 = 12'(i);
      e.addr1 = 12'(i);
      e.data0 = 8'h2D;
      e.data1 = 8'h2D;
      sb_q.push_back(e);
    end
    send(2'b01, 6'd0, 6'd0, 6'h2D);
    repeat (500) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_we", {ramWe0, ramWe1}, 2'b00);
    chk("abort_front", frontBuffer, 1'b0);
    chk("abort_ready", cmdReady, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_ready_after", cmdReady, 1'b1);
    chk("abort_swap", swapPending, 1'b0);
    chk("abort_drained", sb_q.size(), 0);

    // Reserved op: no writes, stays ready
    send(2'b11, 6'd7, 6'd7, 6'h3F);
    @(negedge clk);
    chk("rsvd_ready", cmdReady, 1'b1);
    repeat (3) @(negedge clk);
    chk("final_drained", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
